// File: rtl/crc_frame_tx_pkg.sv
// Shared types for the CRC-16 transmit framer: FSM state encoding,
// CRC initial value and the byte bit-reversal helper.
package crc_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CRC_HI  = 3'd3,
        ST_CRC_LO  = 3'd4,
        ST_DROP    = 3'd5
    } state_t;

    localparam logic [15:0] CRC_INIT = 16'h0000;

    function automatic logic [7:0] bitrev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = x[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_frame_tx_if.sv
// Payload-in / line-out byte streams of the framer.
// master: payload source + line consumer side; slave: the framer.
interface crc_frame_tx_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

endinterface

// File: rtl/crc_frame_tx_crc16_byte_next.sv
// Combinational CRC-16 (x^16+x^12+x^5+1) byte step, data taken LSB first.
// Ports: crc (current register), d (data byte), next (updated register).
module crc16_byte_next
    import crc_frame_tx_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  d,
    output logic [15:0] next
);

    logic [7:0] x;
    logic [7:0] y;

    // Table-free form of the byte update: fold the high byte with the
    // bit-reversed data, then scatter it onto taps 0, 5 and 12.
    always_comb begin
        x    = crc[15:8] ^ bitrev8(d);
        y    = x ^ {4'h0, x[7:4]};
        next = {crc[7:0], 8'h00}
             ^ {y[3:0], 12'h000}
             ^ {3'b000, y, 5'b00000}
             ^ {8'h00, y};
    end

endmodule

// File: rtl/crc_frame_tx.sv
// Transmit framer: sync prefix, payload pass-through, CRC-16 trailer.
// Ports: clk, reset (async high), bus (slave streams), busy, len_err, frame_cnt.
module crc_frame_tx
    import crc_frame_tx_pkg::*;
#(
    parameter int         NUM_SYNC  = 2,
    parameter logic [7:0] SYNC_BYTE = 8'h7E,
    parameter int         MAX_LEN   = 256
) (
    input  logic           clk,
    input  logic           reset,
    crc_frame_tx_if.slave  bus,
    output logic           busy,
    output logic           len_err,
    output logic [15:0]    frame_cnt
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int SYNC_W = (NUM_SYNC > 1) ? $clog2(NUM_SYNC) : 1;
    localparam logic [LEN_W-1:0]  LEN_LAST  = LEN_W'(MAX_LEN - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST =
        SYNC_W'((NUM_SYNC > 0) ? NUM_SYNC - 1 : 0);

    state_t            state;
    logic [15:0]       crc;
    logic [15:0]       crc_nxt;
    logic [LEN_W-1:0]  len;
    logic [SYNC_W-1:0] sync_idx;
    logic              drop;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_last;
    logic              load;
    logic              s_ready;
    logic              s_xfer;

    crc16_byte_next u_crc (
        .crc  (crc),
        .d    (bus.s_data),
        .next (crc_nxt)
    );

    // Output register may take a new byte when empty or being drained.
    assign load    = !m_valid || bus.m_ready;
    assign s_ready = ((state == ST_PAYLOAD) && load) || (state == ST_DROP);
    assign s_xfer  = bus.s_valid && s_ready;

    assign bus.s_ready = s_ready;
    assign bus.m_data  = m_data;
    assign bus.m_valid = m_valid;
    assign bus.m_last  = m_last;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            crc       <= CRC_INIT;
            len       <= '0;
            sync_idx  <= '0;
            drop      <= 1'b0;
            m_data    <= 8'h00;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            len_err   <= 1'b0;
            frame_cnt <= 16'h0000;
        end else begin
            len_err <= 1'b0;
            // Empty the output slot by default; states below refill it.
            if (load) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (bus.s_valid) begin
                        crc      <= CRC_INIT;
                        len      <= '0;
                        sync_idx <= '0;
                        drop     <= 1'b0;
                        state    <= (NUM_SYNC > 0) ? ST_SYNC : ST_PAYLOAD;
                    end
                end
                ST_SYNC: begin
                    if (load) begin
                        m_data   <= SYNC_BYTE;
                        m_valid  <= 1'b1;
                        sync_idx <= sync_idx + 1'b1;
                        if (sync_idx == SYNC_LAST) begin
                            state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (s_xfer) begin
                        m_data  <= bus.s_data;
                        m_valid <= 1'b1;
                        crc     <= crc_nxt;
                        len     <= len + 1'b1;
                        if (bus.s_last) begin
                            state <= ST_CRC_HI;
                        end else if (len == LEN_LAST) begin
                            // Over-long frame: close it here, swallow the rest.
                            state   <= ST_CRC_HI;
                            len_err <= 1'b1;
                            drop    <= 1'b1;
                        end
                    end
                end
                ST_CRC_HI: begin
                    if (load) begin
                        m_data  <= ~bitrev8(crc[15:8]);
                        m_valid <= 1'b1;
                        state   <= ST_CRC_LO;
                    end
                end
                ST_CRC_LO: begin
                    if (load) begin
                        m_data    <= ~bitrev8(crc[7:0]);
                        m_valid   <= 1'b1;
                        m_last    <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= drop ? ST_DROP : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (s_xfer && bus.s_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_tx.sv
// Scoreboard bench for crc_frame_tx: two instances (MAX_LEN 256 and 4),
// random payloads/gaps/backpressure against a bit-serial CRC reference.
module tb_crc_frame_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    crc_frame_tx_if bus_a ();
    crc_frame_tx_if bus_b ();

    logic        busy_a, busy_b, len_err_a, len_err_b;
    logic [15:0] frame_cnt_a, frame_cnt_b;

    crc_frame_tx #(.NUM_SYNC(2), .SYNC_BYTE(8'h7E), .MAX_LEN(256)) dut (
        .clk(clk), .reset(reset), .bus(bus_a),
        .busy(busy_a), .len_err(len_err_a), .frame_cnt(frame_cnt_a)
    );

    crc_frame_tx #(.NUM_SYNC(2), .SYNC_BYTE(8'h7E), .MAX_LEN(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus_b),
        .busy(busy_b), .len_err(len_err_b), .frame_cnt(frame_cnt_b)
    );

    int checks = 0;
    int passed = 0;
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    int exp_cnt_a = 0, exp_cnt_b = 0;
    int exp_lerr_a = 0, exp_lerr_b = 0;
    int lerr_a = 0, lerr_b = 0;
    bit ignore_a = 1'b0;
    int rdy_pct = 100;
    int gap_pct = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Reference CRC: whole message, bit at a time, LSB of each byte first.
    function automatic logic [15:0] crc_ref(input logic [7:0] msg[$]);
        logic [15:0] r;
        logic fb;
        r = 16'h0000;
        foreach (msg[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[15] ^ msg[k][b];
                r = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] rev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = x[i];
        return r;
    endfunction

    task automatic push_exp(input bit sel, input logic [8:0] v);
        if (sel) exp_b.push_back(v);
        else exp_a.push_back(v);
    endtask

    task automatic expect_frame(input bit sel, input logic [7:0] pay[$],
                                input int max_len);
        logic [7:0] kept[$];
        logic [15:0] c;
        foreach (pay[i]) if (i < max_len) kept.push_back(pay[i]);
        push_exp(sel, 9'h07E);
        push_exp(sel, 9'h07E);
        foreach (kept[i]) push_exp(sel, {1'b0, kept[i]});
        c = crc_ref(kept);
        push_exp(sel, {1'b0, ~rev(c[15:8])});
        push_exp(sel, {1'b1, ~rev(c[7:0])});
        if (sel) begin
            exp_cnt_b++;
            if (pay.size() > max_len) exp_lerr_b++;
        end else begin
            exp_cnt_a++;
            if (pay.size() > max_len) exp_lerr_a++;
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d,
                         input logic l);
        if (sel) begin
            bus_b.s_valid = v; bus_b.s_data = d; bus_b.s_last = l;
        end else begin
            bus_a.s_valid = v; bus_a.s_data = d; bus_a.s_last = l;
        end
    endtask

    // Entered at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic wait_accept(input bit sel);
        int n = 0;
        @(negedge clk);
        while (!(sel ? bus_b.s_ready : bus_a.s_ready)) begin
            n++;
            if (n > 5000) begin
                $display("FAIL accept_timeout: s_ready 0 for %0d cycles, required 1", n);
                $fatal(1, "stalled");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] pay[$]);
        foreach (pay[i]) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                drive(sel, 1'b0, 8'h00, 1'b0);
                @(posedge clk);
                #1;
            end
            drive(sel, 1'b1, pay[i], i == pay.size() - 1);
            wait_accept(sel);
        end
        drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rand_frame(input bit sel, input int len, input int max_len);
        logic [7:0] pay[$];
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
        expect_frame(sel, pay, max_len);
        send(sel, pay);
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? (exp_b.size() != 0 || busy_b)
                    : (exp_a.size() != 0 || busy_a)) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(n >= 20000), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.m_ready = 1'b0;
        bus_b.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus_a.m_ready = ($urandom_range(0, 99) < rdy_pct);
            bus_b.m_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (len_err_a) lerr_a++;
            if (len_err_b) lerr_b++;
            if (bus_a.m_valid && bus_a.m_ready && !ignore_a) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    $display("FAIL a_extra: got %h, required no byte", bus_a.m_data);
                end else begin
                    check("a_byte", 32'({bus_a.m_last, bus_a.m_data}),
                          32'(exp_a.pop_front()));
                end
            end
            if (bus_b.m_valid && bus_b.m_ready) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    $display("FAIL b_extra: got %h, required no byte", bus_b.m_data);
                end else begin
                    check("b_byte", 32'({bus_b.m_last, bus_b.m_data}),
                          32'(exp_b.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [7:0] p[$];
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("rst_m_valid", 32'(bus_a.m_valid), 32'd0);
        check("rst_m_data", 32'(bus_a.m_data), 32'd0);
        check("rst_m_last", 32'(bus_a.m_last), 32'd0);
        check("rst_s_ready", 32'(bus_a.s_ready), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_len_err", 32'(len_err_a), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt_a), 32'd0);
        check("rst_b_all", 32'({bus_b.m_valid, bus_b.m_data, bus_b.m_last,
                                busy_b, len_err_b, frame_cnt_b}), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single zero byte, then single 0x80 byte.
        push_exp(1'b0, 9'h07E); push_exp(1'b0, 9'h07E);
        push_exp(1'b0, 9'h000); push_exp(1'b0, 9'h0FF); push_exp(1'b0, 9'h1FF);
        exp_cnt_a++;
        p = {8'h00};
        send(1'b0, p);
        wait_idle(1'b0);
        check("cnt_after_1", 32'(frame_cnt_a), 32'd1);
        push_exp(1'b0, 9'h07E); push_exp(1'b0, 9'h07E);
        push_exp(1'b0, 9'h080); push_exp(1'b0, 9'h0F7); push_exp(1'b0, 9'h17B);
        exp_cnt_a++;
        p = {8'h80};
        send(1'b0, p);
        wait_idle(1'b0);
        check("cnt_after_2", 32'(frame_cnt_a), 32'd2);

        // Random frames with gaps and backpressure, including length limits.
        rdy_pct = 70;
        gap_pct = 25;
        rand_frame(1'b0, 1, 256);
        rand_frame(1'b0, 256, 256);
        for (int f = 0; f < 10; f++) rand_frame(1'b0, $urandom_range(1, 256), 256);
        wait_idle(1'b0);
        check("cnt_rand_a", 32'(frame_cnt_a), 32'(exp_cnt_a));
        check("lerr_rand_a", 32'(lerr_a), 32'(exp_lerr_a));

        // Truncation on the MAX_LEN=4 instance, then a clean frame.
        rand_frame(1'b1, 6, 4);
        rand_frame(1'b1, 3, 4);
        wait_idle(1'b1);
        check("lerr_trunc", 32'(lerr_b), 32'd1);
        check("cnt_trunc", 32'(frame_cnt_b), 32'd2);
        rand_frame(1'b1, 4, 4);
        for (int f = 0; f < 12; f++) rand_frame(1'b1, $urandom_range(1, 7), 4);
        wait_idle(1'b1);
        check("lerr_rand_b", 32'(lerr_b), 32'(exp_lerr_b));
        check("cnt_rand_b", 32'(frame_cnt_b), 32'(exp_cnt_b));

        // Reset in the middle of a payload.
        rdy_pct = 100;
        gap_pct = 0;
        @(posedge clk);
        #1;
        ignore_a = 1'b1;
        drive(1'b0, 1'b1, 8'h11, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("busy_mid", 32'(busy_a), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_m_valid", 32'(bus_a.m_valid), 32'd0);
        check("abort_m_data", 32'(bus_a.m_data), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_cnt", 32'(frame_cnt_a), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        exp_a.delete();
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ignore_a = 1'b0;
        gap_pct = 25;
        rdy_pct = 70;
        rand_frame(1'b0, 5, 256);
        wait_idle(1'b0);
        check("cnt_post_rst", 32'(frame_cnt_a), 32'd1);

        // Counter wrap.
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt;
        @(posedge clk);
        #1;
        check("cnt_preload", 32'(frame_cnt_a), 32'h0000FFFF);
        rand_frame(1'b0, 3, 256);
        wait_idle(1'b0);
        check("cnt_wrap", 32'(frame_cnt_a), 32'd0);
        check("a_queue_empty", 32'(exp_a.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
